// File: rtl/spawn_scheduler.sv
// Spawn scheduler: requests a random value from the generator, turns it into
// a delay in game ticks, counts it down and then offers a spawn request with
// a lane index over a valid/ready handshake.
module spawn_scheduler #(
  parameter logic [4:0] RANGE     = 5'd10,
  parameter logic [4:0] MIN_DELAY = 5'd1,
  parameter int         LANE_W    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              tick,
  input  logic [4:0]        rnd_in,
  output logic              rnd_req,
  output logic [4:0]        rnd_range,
  output logic              spawn_valid,
  input  logic              spawn_ready,
  output logic [LANE_W-1:0] spawn_lane,
  output logic [7:0]        spawn_cnt,
  output logic              busy
);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    SAMPLE,
    COUNT,
    SPAWN
  } state_t;

  state_t            state;
  state_t            next_state;
  logic [4:0]        delay_cnt;
  logic [LANE_W-1:0] lane_q;
  logic [7:0]        cnt_q;
  logic              tick_en;
  logic              accept;

  assign tick_en = tick & enable;
  assign accept  = (state == SPAWN) & spawn_ready;

  // State register; reset drops any pending spawn immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; REQ/SAMPLE always run to completion regardless of enable.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (enable) next_state = REQ;
      REQ:     next_state = SAMPLE;
      SAMPLE:  next_state = COUNT;
      COUNT:   if (tick_en && (delay_cnt == 5'd1)) next_state = SPAWN;
      SPAWN:   if (accept) next_state = enable ? REQ : IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Delay counter and lane capture; the load is clamped so the count never underflows.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      delay_cnt <= 5'd0;
      lane_q    <= '0;
    end else if (state == SAMPLE) begin
      delay_cnt <= (rnd_in < MIN_DELAY) ? MIN_DELAY : rnd_in;
      lane_q    <= rnd_in[LANE_W-1:0];
    end else if ((state == COUNT) && tick_en) begin
      delay_cnt <= delay_cnt - 5'd1;
    end
  end

  // Saturating count of accepted spawns.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 8'd0;
    end else if (accept && (cnt_q != 8'd255)) begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

  assign rnd_req     = (state == REQ);
  assign rnd_range   = RANGE;
  assign spawn_valid = (state == SPAWN);
  assign spawn_lane  = lane_q;
  assign spawn_cnt   = cnt_q;
  assign busy        = (state != IDLE);

endmodule

// File: doc/spawn_scheduler.md
Name: spawn_scheduler

Overview:
- Consumer side of the 5-bit pseudo-random generator.
- Requests one random value per spawn event and turns it into a delay measured in game ticks.
- Counts that delay down, then presents a spawn request with a lane index to the game-object logic through a valid/ready handshake.
- Sits between the random generator and the obstacle/object manager.

Parameters:
- RANGE, 5'd10: constant driven on rnd_range; must be nonzero.
- MIN_DELAY, 5'd1: lower clamp on the loaded delay, in ticks; must be at least 1.
- LANE_W, 2: width of spawn_lane; number of lanes is 2**LANE_W.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- enable  in  1  run/pause; low freezes the countdown.
- tick  in  1  one-cycle game-tick strobe.
- rnd_in  in  5  random value from the generator.
- rnd_req  out  1  one-cycle request pulse to the generator (drives its gen input).
- rnd_range  out  5  range to the generator; constant RANGE.
- spawn_valid  out  1  spawn request pending.
- spawn_ready  in  1  consumer accepts the spawn.
- spawn_lane  out  LANE_W  lane for the pending spawn.
- spawn_cnt  out  8  count of accepted spawns; saturates at 255.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset values: rnd_req=0, spawn_valid=0, spawn_lane=0, spawn_cnt=0, busy=0, delay counter=0, state=IDLE. rnd_range is always RANGE.
- States: IDLE, REQ, SAMPLE, COUNT, SPAWN.
- IDLE:
  - With enable=1, go to REQ next cycle.
  - Otherwise stay in IDLE.
- REQ:
  - rnd_req=1 for exactly this one cycle.
  - Always go to SAMPLE.
- SAMPLE:
  - rnd_in is captured in this cycle, one cycle after the rnd_req pulse.
  - Delay counter loads max(rnd_in, MIN_DELAY).
  - spawn_lane register loads rnd_in[LANE_W-1:0].
  - Go to COUNT.
  - enable is ignored in REQ and SAMPLE; the request/sample pair always completes.
- COUNT:
  - On each cycle with tick=1 and enable=1, decrement the counter.
  - If the counter is 1 while tick=1 and enable=1, go to SPAWN next cycle with the counter at 0.
  - A delay of N means spawn_valid rises the cycle after the Nth qualifying tick.
  - tick with enable=0 is ignored and not queued.
- SPAWN:
  - spawn_valid=1, and spawn_lane stays stable until accepted.
  - Acceptance is spawn_valid && spawn_ready in the same cycle.
  - On acceptance: spawn_cnt increments unless it is already 255; state goes to REQ next cycle if enable=1, else IDLE.
  - spawn_valid is never dropped without acceptance, including when enable falls.
  - tick is ignored in SPAWN.
- Width rules:
  - Counter is 5 bits and never underflows, since MIN_DELAY≥1 guarantees a load ≥1.
  - spawn_cnt is saturating unsigned.
- Asynchronous rst in any state returns all registers to their reset values immediately. A pending spawn is discarded, not counted.
- Throughput: a delay of N gives at least N tick periods plus 3 clk cycles between consecutive spawns (REQ, SAMPLE, accept).

Test Plan:
1. Reset, enable=1, rnd_in=5'd7 when sampled, tick every 4 clks, spawn_ready=1 → rnd_req is a single pulse 1 cycle after leaving IDLE; spawn_valid rises the cycle after the 7th tick with spawn_lane=2'd3; spawn_cnt becomes 1.
2. rnd_in=5'd0 when sampled, MIN_DELAY=1 → counter loads 1; spawn_valid rises the cycle after the first tick.
3. spawn_ready=0 for 10 clks with spawn_valid high, tick toggling, enable dropped to 0 → spawn_valid and spawn_lane stay stable. When spawn_ready rises, spawn_cnt increments and state goes to IDLE with no new rnd_req.
4. Pause: delay 6, enable low after 3 ticks for 5 ticks, then high → spawn_valid rises the cycle after the 6th enabled tick, i.e. 11 ticks total.
5. Assert rst mid-COUNT and again during SPAWN → all outputs return to their reset values immediately; spawn_cnt does not increment; the next rnd_req appears 1 cycle after rst releases with enable=1.
6. Run 260 accepted spawns with rnd_in=5'd1 → spawn_cnt saturates at 255 and never wraps.
